// File: rtl/select_action_multi.sv
// select_action_multi: per-round action selection (best hop, first live
// in-cluster sink, or LFSR-gated exploration hop). When no destination
// survives, the node becomes cluster head and writes its aggregation flag.
module select_action_multi #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NUM_SINKS  = 4,
  parameter int unsigned NONE_ID    = 65,
  parameter int unsigned FLAG_ADDR  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            start,
  input  logic [WORD_WIDTH-1:0]           nexthop,
  input  logic [WORD_WIDTH-1:0]           randhop,
  input  logic [NUM_SINKS*WORD_WIDTH-1:0] nextsinks,
  input  logic [7:0]                      epsilon,
  output logic [WORD_WIDTH-1:0]           action,
  output logic [1:0]                      action_src,
  output logic                            forAggregation,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           address,
  output logic [WORD_WIDTH-1:0]           data_out,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned IDX_W = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
  localparam logic [WORD_WIDTH-1:0] L_NONE = WORD_WIDTH'(NONE_ID);
  localparam logic [IDX_W-1:0]      L_LAST = IDX_W'(NUM_SINKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SCAN, S_EXPLORE, S_DECIDE, S_WRITE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [15:0]           r_lfsr;
  logic [WORD_WIDTH-1:0] r_sinks [NUM_SINKS];
  logic [WORD_WIDTH-1:0] r_randhop;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_hit;

  logic [WORD_WIDTH-1:0] r_action;
  logic [1:0]            r_src;
  logic                  r_agg;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_done;

  logic [WORD_WIDTH-1:0] w_slot;
  logic                  w_slot_hit;
  logic                  w_explore;

  assign w_slot     = r_sinks[r_idx];
  assign w_slot_hit = (w_slot != L_NONE);
  assign w_explore  = !r_hit && (epsilon != 8'd0) && (r_randhop != L_NONE) &&
                      (r_lfsr[7:0] < epsilon);

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1, advances every cycle
  always_ff @(posedge clock) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // State register
  always_ff @(posedge clock) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (en)    w_next = S_WAIT;
      S_WAIT:    if (start) w_next = S_SCAN;
      S_SCAN:    if (w_slot_hit || (r_idx == L_LAST)) w_next = S_EXPLORE;
      S_EXPLORE: w_next = S_DECIDE;
      S_DECIDE:  w_next = S_WRITE;
      S_WRITE:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Round datapath: capture, sink scan, exploration, CH decision and flag write
  always_ff @(posedge clock) begin
    if (rst) begin
      r_action  <= '0;
      r_src     <= '0;
      r_agg     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_randhop <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      for (int unsigned i = 0; i < NUM_SINKS; i++) r_sinks[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            r_agg   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (start) begin
            r_action  <= nexthop;
            r_src     <= 2'd0;
            r_randhop <= randhop;
            for (int unsigned i = 0; i < NUM_SINKS; i++)
              r_sinks[i] <= nextsinks[i*WORD_WIDTH +: WORD_WIDTH];
            r_idx     <= '0;
            r_hit     <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_slot_hit) begin
            r_action <= w_slot;
            r_src    <= 2'd1;
            r_hit    <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_EXPLORE: begin
          if (w_explore) begin
            r_action <= r_randhop;
            r_src    <= 2'd2;
          end
        end
        S_DECIDE: begin
          if (r_action == L_NONE) begin
            r_agg     <= 1'b1;
            r_wr_en   <= 1'b1;
            r_address <= ADDR_WIDTH'(FLAG_ADDR);
            r_data    <= WORD_WIDTH'(1);
            r_src     <= 2'd3;
          end
        end
        S_WRITE: r_wr_en <= 1'b0;
        S_DONE:  r_done  <= 1'b1;
        default: ;
      endcase
    end
  end

  assign action         = r_action;
  assign action_src     = r_src;
  assign forAggregation = r_agg;
  assign wr_en          = r_wr_en;
  assign address        = r_address;
  assign data_out       = r_data;
  assign done           = r_done;
  assign busy           = (r_state != S_IDLE) && (r_state != S_WAIT);

endmodule

// File: tb/tb_select_action_multi.sv
// Scoreboard bench for select_action_multi: expected round results are queued
// when start is driven and compared when done rises.
module tb_select_action_multi;

  localparam int W = 16;
  localparam int NS = 4;
  localparam logic [15:0] NONE = 16'd65;
  localparam logic [63:0] ALL_NONE = {4{16'd65}};

  logic        clock = 1'b0;
  logic        rst, en, start;
  logic [15:0] nexthop, randhop;
  logic [63:0] nextsinks;
  logic [7:0]  epsilon;
  logic [15:0] action;
  logic [1:0]  action_src;
  logic        forAggregation, wr_en, busy, done;
  logic [10:0] address;
  logic [15:0] data_out;

  always #5 clock = ~clock;

  select_action_multi #(
    .WORD_WIDTH(16), .ADDR_WIDTH(11), .NUM_SINKS(4),
    .NONE_ID(65), .FLAG_ADDR(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .nexthop(nexthop), .randhop(randhop), .nextsinks(nextsinks), .epsilon(epsilon),
    .action(action), .action_src(action_src), .forAggregation(forAggregation),
    .wr_en(wr_en), .address(address), .data_out(data_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic [15:0] action;
    logic [1:0]  src;
    logic        agg;
    int          wr;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          round_wr = 0;
  logic        prev_done = 1'b0;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Reference LFSR and cycle counter
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? 16'hACE1 : lfsr_step(m_lfsr);
  end

  // Monitor: write-strobe contents, and scoreboard pop on done rising
  always @(negedge clock) begin
    if (wr_en) begin
      round_wr++;
      check("wr_addr", 32'(address), 32'd2);
      check("wr_data", 32'(data_out), 32'd1);
    end
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("action", 32'(action), 32'(mon_e.action));
        check("src", 32'(action_src), 32'(mon_e.src));
        check("agg", 32'(forAggregation), 32'(mon_e.agg));
        check("wr_pulses", 32'(round_wr), 32'(mon_e.wr));
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
      end
    end
    prev_done = done;
  end

  // One full round; optionally en+start together in IDLE, and optional
  // mid-round disturbance of inputs/start/en.
  task automatic run_round(input logic [15:0] nh, input logic [15:0] rh,
                           input logic [63:0] sinks, input logic [7:0] eps,
                           input bit together, input bit perturb);
    exp_t        e;
    int          s;
    logic        hit;
    logic [15:0] lf;
    logic [15:0] slot;
    @(negedge clock);
    en    = 1'b1;
    start = together;
    if (together) begin
      nexthop   = 16'(NONE);
      randhop   = 16'd77;
      nextsinks = {16'd11, 16'd22, 16'd33, 16'd44};
      epsilon   = eps;
    end
    @(negedge clock);
    en        = 1'b0;
    start     = 1'b1;
    nexthop   = nh;
    randhop   = rh;
    nextsinks = sinks;
    epsilon   = eps;
    hit       = 1'b0;
    s         = NS;
    e.action  = nh;
    e.src     = 2'd0;
    for (int i = 0; i < NS; i++) begin
      slot = sinks[i*W +: W];
      if (!hit && slot != NONE) begin
        hit      = 1'b1;
        s        = i + 1;
        e.action = slot;
        e.src    = 2'd1;
      end
    end
    lf = m_lfsr;
    for (int i = 0; i <= s; i++) lf = lfsr_step(lf);
    if (!hit && eps != 8'd0 && rh != NONE && lf[7:0] < eps) begin
      e.action = rh;
      e.src    = 2'd2;
    end
    e.agg = 1'b0;
    e.wr  = 0;
    if (e.action == NONE) begin
      e.src = 2'd3;
      e.agg = 1'b1;
      e.wr  = 1;
    end
    e.done_cyc = cyc + 1 + s + 4;
    sb.push_back(e);
    round_wr = 0;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    if (perturb) begin
      nexthop   = ~nh;
      randhop   = 16'd99;
      nextsinks = {16'd1, 16'd2, 16'd3, 16'd4};
      start     = 1'b1;
      en        = 1'b1;
      @(negedge clock);
      start = 1'b0;
      en    = 1'b0;
    end
    for (int k = 0; k < 40 && !done; k++) @(negedge clock);
    if (!done) begin
      check("done_timeout", 32'(done), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(negedge clock);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0;
    nexthop = '0; randhop = '0; nextsinks = '0; epsilon = '0;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    check("rst_action", 32'(action), 32'd0);
    check("rst_src", 32'(action_src), 32'd0);
    check("rst_agg", 32'(forAggregation), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // best hop, sink hit at slot 1, cluster-head round
    run_round(16'd7, NONE, ALL_NONE, 8'd0, 1'b0, 1'b0);
    run_round(16'd7, NONE, {16'd65, 16'd30, 16'd12, 16'd65}, 8'd0, 1'b0, 1'b0);
    run_round(NONE, NONE, ALL_NONE, 8'd0, 1'b0, 1'b0);

    // start alone in IDLE is ignored; done and the CH result stay held
    @(negedge clock);
    start = 1'b1;
    nexthop = 16'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_start_busy", 32'(busy), 32'd0);
    check("idle_start_done", 32'(done), 32'd1);
    check("held_action", 32'(action), 32'(NONE));
    check("held_src", 32'(action_src), 32'd3);

    // en+start together, then disturbances mid-round
    run_round(16'd5, NONE, {16'd20, 16'd65, 16'd65, 16'd65}, 8'd0, 1'b1, 1'b1);
    run_round(16'd8, 16'd9, ALL_NONE, 8'd200, 1'b1, 1'b1);

    // exploration sweep
    for (int r = 0; r < 256; r++) run_round(16'd7, 16'd9, ALL_NONE, 8'd255, 1'b0, 1'b0);
    for (int r = 0; r < 20; r++)  run_round(16'd3, NONE, ALL_NONE, 8'd255, 1'b0, 1'b0);

    // reset during SCAN of a would-be CH round
    @(negedge clock);
    en = 1'b1;
    @(negedge clock);
    en = 1'b0; start = 1'b1;
    nexthop = NONE; randhop = NONE; nextsinks = ALL_NONE; epsilon = 8'd0;
    @(negedge clock);
    start = 1'b0;
    round_wr = 0;
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    check("mid_rst_action", 32'(action), 32'd0);
    check("mid_rst_src", 32'(action_src), 32'd0);
    check("mid_rst_agg", 32'(forAggregation), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(address), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clock);
    check("mid_rst_no_write", 32'(round_wr), 32'd0);
    check("mid_rst_stays_idle", 32'(busy), 32'd0);
    run_round(16'd4, NONE, {16'd65, 16'd65, 16'd65, 16'd3}, 8'd0, 1'b0, 1'b0);

    // randomised rounds
    for (int r = 0; r < 60; r++) begin
      logic [63:0] sk;
      logic [15:0] nh, rh;
      for (int i = 0; i < NS; i++)
        sk[i*W +: W] = ($urandom_range(0, 2) != 0) ? NONE : 16'($urandom_range(0, 200));
      nh = ($urandom_range(0, 3) == 0) ? NONE : 16'($urandom_range(0, 200));
      rh = ($urandom_range(0, 3) == 0) ? NONE : 16'($urandom_range(0, 200));
      run_round(nh, rh, sk, 8'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/select_action_multi.md
# select_action_multi

Parametrised action-selection engine for the routing/clustering node. Per decision round it picks the packet's next action: the best hop, the lowest-indexed available in-cluster sink among `NUM_SINKS` candidates, or an exploration (random) hop gated by a free-running LFSR against an epsilon threshold. If no destination survives (action equals the "none" ID), the node takes the cluster-head role and writes the aggregation flag to node memory. It sits between the Q-value/neighbour lookup stage and the packet-forwarding stage, and uses the same `en`/`start`/`done` round handshake as the other pipeline blocks.

## Interface
- `WORD_WIDTH`, 16, width of node IDs/actions and memory data
- `ADDR_WIDTH`, 11, memory address width
- `NUM_SINKS`, 4, number of candidate sink slots (≥1)
- `NONE_ID`, 65, sentinel meaning "no node"
- `FLAG_ADDR`, 2, memory address of the forAggregation flag
- `LFSR_SEED`, 16'hACE1, LFSR reset value (non-zero)
- `clock`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  arm a new round (sampled only in IDLE)
- `start`  in  1  begin selection (sampled only in WAIT)
- `nexthop`  in  WORD_WIDTH  best hop from Q-table
- `randhop`  in  WORD_WIDTH  exploration candidate
- `nextsinks`  in  NUM_SINKS*WORD_WIDTH  packed sink IDs; slot i = bits [i*W +: W]; NONE_ID = empty
- `epsilon`  in  8  exploration threshold
- `action`  out  WORD_WIDTH  selected action
- `action_src`  out  2  0 = besthop, 1 = sink, 2 = explore, 3 = self/CH
- `forAggregation`  out  1  high when the node becomes CH this round
- `wr_en`  out  1  memory write strobe
- `address`  out  ADDR_WIDTH  memory write address
- `data_out`  out  WORD_WIDTH  memory write data
- `busy`  out  1  high in SCAN..DONE
- `done`  out  1  round complete; held until next `en`

## Operation
- States: IDLE, WAIT, SCAN, EXPLORE, DECIDE, WRITE, DONE.
- IDLE: if `en`, clear `done`, `wr_en`, `forAggregation` and go to WAIT. Otherwise hold.
- WAIT: if `start`, latch `nexthop` into `action`, set `action_src` = 0, capture `nextsinks` and `randhop` into internal registers, set scan index = 0, clear the hit flag, and go to SCAN. Later input changes are ignored.
- SCAN: examine one captured slot per cycle, from index 0 upward.
  - First slot ≠ NONE_ID: `action` = slot, `action_src` = 1, set hit, go to EXPLORE.
  - Otherwise advance; after slot NUM_SINKS-1 with no hit, go to EXPLORE.
- EXPLORE: if no hit, `epsilon` ≠ 0, captured `randhop` ≠ NONE_ID and LFSR[7:0] < `epsilon` (unsigned), then `action` = randhop and `action_src` = 2. Go to DECIDE.
- DECIDE: if `action` == NONE_ID, set `forAggregation` = 1, `wr_en` = 1, `address` = FLAG_ADDR, `data_out` = 1 and `action_src` = 3. Go to WRITE.
- WRITE: `wr_en` = 0. Go to DONE.
- DONE: `done` = 1. Go to IDLE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle, including IDLE. Reset value is LFSR_SEED.
- `en` outside IDLE and `start` outside WAIT are ignored. `start` and `en` asserted together in IDLE: only `en` acts.

## Timing
- Reset values: `action` = 0, `action_src` = 0, `forAggregation` = 0, `wr_en` = 0, `address` = 0, `data_out` = 0, `done` = 0, `busy` = 0; state = IDLE.
- Reset asserted mid-round: abort next edge with the reset values above. No write is issued or completed.
- Let S = h+1 when the first hit is at slot h, or S = NUM_SINKS when there is no hit. `done` rises S+4 edges after the edge that samples `start`.
- `wr_en` is high for exactly one cycle, only in CH rounds. `address` and `data_out` are stable during that cycle and held afterwards.
- `action` and `action_src` are final from the cycle after DECIDE and are held until the next `start`.

## Test plan
- Reset, then `en`, then `start` with nexthop = 7 and all sinks = 65, epsilon = 0 -> `action` = 7, `action_src` = 0, no `wr_en`, `done` after 8 edges.
- nexthop = 7, sinks = {65, 12, 30, 65} (slots 0..3) -> `action` = 12, `action_src` = 1, `done` after 6 edges.
- nexthop = 65, all sinks = 65, epsilon = 0 -> `action` = 65, `action_src` = 3, `forAggregation` = 1, one-cycle `wr_en` with `address` = 2 and `data_out` = 1.
- No sinks, epsilon = 255, randhop = 9, run 256 rounds -> `action` = 9 with `action_src` = 2 exactly when the model LFSR[7:0] < 255. With randhop = 65, exploration never occurs.
- `rst` asserted during SCAN -> all outputs return to reset values and no `wr_en` pulse occurs. A fresh `en`/`start` then completes normally.
- `start` pulsed in IDLE and mid-round, and inputs changed during SCAN -> ignored; the result matches the values captured at the legal `start`.
